// File: rtl/nibble_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_adder_pkg
//
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W : width of one nibble; matches the operand width of full_adder.
//   state_t  : control FSM states of nibble_serial_adder.
// -----------------------------------------------------------------------------
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE, // waiting for operands, in_ready high
    RUN,  // one nibble per cycle through full_adder
    DONE  // result presented, waiting for out_ready
  } state_t;

endpackage : nibble_adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// 4-bit combinational adder: {cout, sum} = a + b + cin.
//
// Ports
//   a    in  4  operand A
//   b    in  4  operand B
//   cin  in  1  carry in
//   sum  out 4  sum nibble
//   cout out 1  carry out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Widen every term to 5 bits so the carry out is captured explicitly.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule : full_adder

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Wide adder that reuses a single 4-bit full_adder, processing one nibble per
// cycle from least significant to most significant and carrying between
// nibbles in a register. Operands arrive on a valid/ready handshake and the
// result leaves on another one.
//   {out_cout, out_sum} = in_a + in_b + in_cin   (mod 2^(W+1))
//
// Latency from acceptance edge to out_valid is NIBBLES cycles; with out_ready
// tied high a new operation can start every NIBBLES+2 cycles.
//
// Parameters
//   NIBBLES   nibbles per operand (2..16); W = 4*NIBBLES
//
// Ports
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous reset, active high
//   in_valid   in  1  operands presented
//   in_ready   out 1  block can accept operands (IDLE only)
//   in_a       in  W  operand A
//   in_b       in  W  operand B
//   in_cin     in  1  carry into nibble 0
//   out_valid  out 1  result available (DONE only)
//   out_ready  in  1  consumer accepts result
//   out_sum    out W  sum; held until the next result replaces it
//   out_cout   out 1  carry out of the top nibble
// -----------------------------------------------------------------------------
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);

  localparam int                IDX_W    = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state;
  logic [IDX_W-1:0]   idx;      // nibble currently being added
  logic               carry;    // carry into nibble idx
  logic [W-1:0]       a_reg;    // operands latched at acceptance
  logic [W-1:0]       b_reg;
  logic [W-1:0]       acc;      // partial result, nibbles below idx valid

  logic               accept;

  // full_adder connections
  logic [NIBBLE_W-1:0] fa_a;
  logic [NIBBLE_W-1:0] fa_b;
  logic [NIBBLE_W-1:0] fa_sum;
  logic                fa_cout;

  logic [W-1:0]        next_acc;

  // in_ready is registered and only ever high in IDLE, so it alone qualifies
  // the input handshake; in_valid is ignored in every other state.
  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Nibble datapath: operand mux -> full_adder -> result nibble insert
  // ---------------------------------------------------------------------------
  assign fa_a = a_reg[NIBBLE_W*idx +: NIBBLE_W];
  assign fa_b = b_reg[NIBBLE_W*idx +: NIBBLE_W];

  full_adder u_full_adder (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // NOTE: every signal assigned in always_comb gets a full default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_acc                          = acc;
    next_acc[NIBBLE_W*idx +: NIBBLE_W] = fa_sum;
  end

  // ---------------------------------------------------------------------------
  // Operand and accumulator registers
  // ---------------------------------------------------------------------------
  // NOTE: pure datapath registers are left without reset; they are always
  // written before being read (operands at acceptance, every accumulator
  // nibble during RUN), so a reset would only add a mux on each bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
    end
    if (state == RUN) begin
      acc <= next_acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Aborts any operation in flight and clears the visible result.
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            state    <= RUN;
            idx      <= '0;
            carry    <= in_cin;
            in_ready <= 1'b0;
          end
        end

        RUN: begin
          carry <= fa_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Publish the whole result at once so out_sum never shows a
            // half-updated mix of the old and new sums.
            state     <= DONE;
            idx       <= '0;
            out_valid <= 1'b1;
            out_sum   <= next_acc;
            out_cout  <= fa_cout;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          idx       <= '0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed self-checking bench for nibble_serial_adder with NIBBLES = 4.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int TIMEOUT = 40;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  int total;
  int bad;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents operands and returns 1 ns after the
  // acceptance edge with in_valid dropped.
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    while (in_ready !== 1'b1 && n < TIMEOUT) begin
      step();
      n++;
    end
    if (in_ready !== 1'b1) begin
      timed_out = 1'b1;
    end else begin
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      step();
      in_valid = 1'b0;
    end
  endtask

  // Counts edges from acceptance until out_valid is seen.
  task automatic wait_result(output int lat, output bit timed_out);
    lat = 0;
    timed_out = 1'b0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      step();
      lat++;
    end
    if (out_valid !== 1'b1) timed_out = 1'b1;
  endtask

  // Runs one complete add with out_ready high and checks value and latency.
  task automatic run_and_check(input string name, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic cin,
                               input logic [W-1:0] exp_sum, input logic exp_cout);
    bit to;
    int lat;
    accept_op(a, b, cin, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL %s accept timeout: in_ready never high", name);
      return;
    end
    wait_result(lat, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL %s result timeout: out_valid never high", name);
      return;
    end
    total++;
    if (lat != NIBBLES) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, NIBBLES);
    end
    total++;
    if (out_sum !== exp_sum || out_cout !== exp_cout) begin
      bad++;
      $display("FAIL %s result: got sum=%h cout=%b want sum=%h cout=%b",
               name, out_sum, out_cout, exp_sum, exp_cout);
    end
    step(); // handshake with out_ready high
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s post-handshake: got out_valid=%b in_ready=%b want 0/1",
               name, out_valid, in_ready);
    end
    total++;
    if (out_sum !== exp_sum || out_cout !== exp_cout) begin
      bad++;
      $display("FAIL %s hold after handshake: got sum=%h cout=%b want sum=%h cout=%b",
               name, out_sum, out_cout, exp_sum, exp_cout);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0) begin
      bad++;
      $display("FAIL reset values: got in_ready=%b out_valid=%b sum=%h cout=%b want 0/0/0000/0",
               in_ready, out_valid, out_sum, out_cout);
    end
    rst = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset release in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_zero();
    run_and_check("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_ripple();
    run_and_check("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_and_check("b2b_first", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
    run_and_check("b2b_second", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
  endtask

  task automatic test_backpressure();
    bit to;
    int lat;
    out_ready = 1'b0;
    accept_op(16'h7A9B, 16'h0465, 1'b0, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL bp accept timeout");
      out_ready = 1'b1;
      return;
    end
    wait_result(lat, to);
    total++;
    if (to || lat != NIBBLES) begin
      bad++;
      $display("FAIL bp latency: got %0d (timeout=%0b) want %0d", lat, to, NIBBLES);
    end
    // Offer a competing operand while stalled; it must not be taken.
    in_valid = 1'b1;
    in_a     = 16'h1111;
    in_b     = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_sum !== 16'h7F00 || out_cout !== 1'b0) begin
        bad++;
        $display("FAIL bp hold cycle %0d: got out_valid=%b in_ready=%b sum=%h cout=%b want 1/0/7f00/0",
                 i, out_valid, in_ready, out_sum, out_cout);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'h7F00) begin
      bad++;
      $display("FAIL bp release: got out_valid=%b in_ready=%b sum=%h want 0/1/7f00",
               out_valid, in_ready, out_sum);
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    accept_op(16'h1111, 16'h2222, 1'b0, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL midrst accept timeout");
      return;
    end
    // idx is 0 now; two more edges bring it to 2.
    step();
    step();
    rst = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst abort: got out_valid=%b sum=%h cout=%b in_ready=%b want 0/0000/0/0",
               out_valid, out_sum, out_cout, in_ready);
    end
    rst = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst recover: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    run_and_check("after_reset", 16'h0009, 16'h0007, 1'b0, 16'h0010, 1'b0);
  endtask

  task automatic test_ignore_inputs();
    bit to;
    int lat;
    accept_op(16'h0F0F, 16'h0101, 1'b0, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL ignore accept timeout");
      return;
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      // Scramble inputs while the operation runs.
      in_valid = ~in_valid;
      in_a     = in_a ^ 16'hFFFF;
      in_b     = 16'hFFFF;
      in_cin   = 1'b1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL ignore in_ready during run: got %b want 0", in_ready);
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || lat != NIBBLES) begin
      bad++;
      $display("FAIL ignore latency: got %0d out_valid=%b want %0d/1", lat, out_valid, NIBBLES);
    end
    total++;
    if (out_sum !== 16'h1010 || out_cout !== 1'b0) begin
      bad++;
      $display("FAIL ignore result: got sum=%h cout=%b want 1010/0", out_sum, out_cout);
    end
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ignore idle: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_zero();
    test_ripple();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_ignore_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nibble_serial_adder
